logic_unit_arbiter: RTL
=======================

// Module: logic_unit_arbiter
// PURPOSE
//   Shares one registered bitwise logic unit (NOT a, NOT b, OR, AND, XOR, NOR,
//   NAND, XNOR) between NREQ requesters. Round-robin arbitration selects one
//   request, captures its opcode and operands, and computes the result. The
//   result is returned with the winner's ID over a valid/ready response port.
//   Sits between client FSMs and the shared gate datapath.
// PARAMETERS
//   NREQ   4   number of requesters (2..8); ID width IDW = $clog2(NREQ)
//   WIDTH  8   operand/result width in bits
// PORTS
//   clk        in   1            rising-edge clock
//   rst_n      in   1            synchronous reset, active low
//   req        in   NREQ         per-requester request, held until granted
//   op         in   3*NREQ       opcode of requester i in op[3*i +: 3]
//   a          in   WIDTH*NREQ   operand A of requester i in a[WIDTH*i +: WIDTH]
//   b          in   WIDTH*NREQ   operand B of requester i, same packing
//   gnt        out  NREQ         one-hot grant, 1-cycle pulse
//   busy       out  1            high whenever state != IDLE
//   rsp_valid  out  1            result valid
//   rsp_ready  in   1            consumer accepts result
//   rsp_id     out  IDW          index of requester owning rsp_data
//   rsp_data   out  WIDTH        result
// BEHAVIOUR
//   Opcodes: 0 ~a, 1 ~b, 2 a|b, 3 a&b, 4 a^b, 5 ~(a|b), 6 ~(a&b), 7 ~(a^b).
//     All operations are bitwise across WIDTH bits.
//   Reset (rst_n low at a clk edge): state=IDLE, gnt=0, rsp_valid=0,
//     rsp_id=0, rsp_data=0, rr_ptr=0. Any in-flight operation is dropped
//     and no response is issued for it.
//   FSM: IDLE -> EXEC -> RESP -> IDLE. All outputs are registered.
//   IDLE: req is sampled only in this state. If req != 0, select the winner:
//     the first set bit searching from rr_ptr upward, wrapping from NREQ-1
//     to 0. At the clock edge: gnt <= onehot(winner); capture op/a/b of the
//     winner; rsp_id <= winner; rr_ptr <= (winner+1) mod NREQ;
//     state <= EXEC. If req == 0, remain in IDLE.
//   EXEC (gnt high for exactly this cycle): at the clock edge, gnt <= 0;
//     rsp_data <= f(captured op, a, b); rsp_valid <= 1; state <= RESP.
//   RESP: rsp_valid, rsp_id and rsp_data are held stable until rsp_ready is
//     high at a clock edge. At that edge, rsp_valid <= 0 and state <= IDLE.
//     rsp_ready is ignored whenever rsp_valid is low.
//   Timing: req seen in IDLE in cycle t -> gnt high in t+1 -> rsp_valid
//     high from t+2. Minimum 3 cycles per operation.
//   Requester contract: deassert req in the cycle after gnt is seen. With
//     this contract, a granted req is never sampled again in IDLE.
//   Inputs are changed only in the captured copy; a requester may change
//     op/a/b after its gnt without affecting the in-flight result.
//   Fairness: a continuously asserted req is granted within NREQ operations.
//   Simultaneous requests: only one grant per IDLE visit; the losers stay
//     pending. rr_ptr advances only on a grant.
// TESTING
//   1 Reset: hold rst_n low 2 cycles with req=4'b1111 -> gnt=0, rsp_valid=0,
//     busy=0, rsp_data=0.
//   2 Single op: req=0001, op0=4, a0=8'hF0, b0=8'h3C, rsp_ready=1 ->
//     gnt=0001 at t+1; rsp_valid at t+2 with rsp_id=0, rsp_data=8'hCC.
//   3 All opcodes on req2 with a=8'hA5, b=8'h0F -> results
//     5A, F0, AF, 05, AA, 50, FA, 55 in order.
//   4 Round robin: req=1111 held, each requester dropping its req after its
//     gnt and re-raising later -> gnt order 0,1,2,3,0.
//   5 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id and
//     rsp_data stable, no new gnt; rsp_ready=1 -> IDLE next cycle.
//   6 Reset mid-operation: rst_n low during EXEC -> no rsp_valid issued;
//     after release, req=0100 -> gnt=0100, since rr_ptr was reset to 0.

Source files
------------

// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - round-robin shared bitwise logic unit with valid/ready response
module logic_unit_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [3*NREQ-1:0]     op,
  input  logic [WIDTH*NREQ-1:0] a,
  input  logic [WIDTH*NREQ-1:0] b,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q;
  logic [NREQ-1:0]  gnt_q;
  logic             busy_q;
  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic             found_d;
  logic [IDW-1:0]   win_d;
  logic [IDW-1:0]   rr_ptr_d;
  logic [WIDTH-1:0] result_d;

  // First pending request at or above rr_ptr, wrapping around.
  always_comb begin
    int j;
    j       = 0;
    found_d = 1'b0;
    win_d   = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found_d && req[j]) begin
        found_d = 1'b1;
        win_d   = IDW'(j);
      end
    end
    rr_ptr_d = (win_d == IDW'(NREQ - 1)) ? '0 : win_d + IDW'(1);
  end

  always_comb begin
    result_d = '0;
    case (op_q)
      3'd0: result_d = ~a_q;
      3'd1: result_d = ~b_q;
      3'd2: result_d = a_q | b_q;
      3'd3: result_d = a_q & b_q;
      3'd4: result_d = a_q ^ b_q;
      3'd5: result_d = ~(a_q | b_q);
      3'd6: result_d = ~(a_q & b_q);
      3'd7: result_d = ~(a_q ^ b_q);
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rr_ptr_q    <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found_d) begin
            gnt_q    <= NREQ'(1) << win_d;
            op_q     <= op[3*win_d +: 3];
            a_q      <= a[WIDTH*win_d +: WIDTH];
            b_q      <= b[WIDTH*win_d +: WIDTH];
            rsp_id_q <= win_d;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= 1'b1;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          gnt_q       <= '0;
          rsp_data_q  <= result_d;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule
